// File: rtl/calc_pkg.sv
// ============================================================================
// calc_pkg: opcodes, key-code constants and parser states for the calculator.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    typedef enum logic [2:0] {
        PUSH = 3'd0,
        ADD  = 3'd1,
        SUB  = 3'd2,
        MUL  = 3'd3,
        DROP = 3'd4,
        CLR  = 3'd5
    } opcode_e;

    localparam logic [3:0] KEY_ADD   = 4'hA;
    localparam logic [3:0] KEY_SUB   = 4'hB;
    localparam logic [3:0] KEY_MUL   = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hD;
    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_DROP  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PUSH_PEND = 2'd1,
        ST_OP_PEND   = 2'd2
    } state_e;

    // Function keys map onto opcodes; anything unrecognised falls to CLR (key E).
    function automatic opcode_e key_to_op(input logic [3:0] k);
        case (k)
            KEY_ADD:  return ADD;
            KEY_SUB:  return SUB;
            KEY_MUL:  return MUL;
            KEY_DROP: return DROP;
            default:  return CLR;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/decimal_accumulator.sv
// ============================================================================
// decimal_accumulator: combinational acc*10+digit with overflow detection.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module decimal_accumulator #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [3:0]       i_digit,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);

    localparam int c_WW = WIDTH + 4;

    logic [c_WW-1:0] w_ext;
    logic [c_WW-1:0] w_wide;

    // Four guard bits hold 10*(2^WIDTH-1)+9 without wrapping.
    assign w_ext  = {4'b0000, i_acc};
    assign w_wide = (w_ext << 3) + (w_ext << 1) + {{WIDTH{1'b0}}, i_digit};
    assign o_sum  = w_wide[WIDTH-1:0];
    assign o_ovf  = |w_wide[c_WW-1:WIDTH];

endmodule

`default_nettype wire

// File: rtl/key_token_parser.sv
// ============================================================================
// key_token_parser: turns keypad tokens into PUSH/operator commands (valid/ready).
// Optional: define PARSER_ECHO_EN to expose entry_value/entry_active outputs.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module key_token_parser
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key_code,
    input  logic             key_valid,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [2:0]       cmd_op,
    output logic [WIDTH-1:0] cmd_data,
    output logic             entry_ovf,
    output logic             key_drop
`ifdef PARSER_ECHO_EN
    ,
    output logic [WIDTH-1:0] entry_value,
    output logic [0:0]       entry_active
`endif
);

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic             r_entry_active, w_active_nxt;
    logic             r_key_prev;
    logic             r_has_op, w_has_op_nxt;
    opcode_e          r_lat_op, w_lat_op_nxt;
    logic             r_cmd_valid, w_cmd_valid_nxt;
    opcode_e          r_cmd_op, w_cmd_op_nxt;
    logic [WIDTH-1:0] r_cmd_data, w_cmd_data_nxt;
    logic             r_entry_ovf, w_ovf_nxt;
    logic             r_key_drop, w_drop_nxt;

    logic             w_event, w_hs, w_is_digit, w_is_oper;
    logic [WIDTH-1:0] w_sum;
    logic             w_digit_ovf;

    assign w_event    = key_valid & ~r_key_prev;
    assign w_hs       = r_cmd_valid & cmd_ready;
    assign w_is_digit = (key_code <= 4'd9);
    assign w_is_oper  = (key_code == KEY_ADD) || (key_code == KEY_SUB) ||
                        (key_code == KEY_MUL) || (key_code == KEY_DROP);

    decimal_accumulator #(.WIDTH(WIDTH)) u_acc (
        .i_acc   (r_acc),
        .i_digit (key_code),
        .o_sum   (w_sum),
        .o_ovf   (w_digit_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    if (w_is_oper)
                        w_state_nxt = r_entry_active ? ST_PUSH_PEND : ST_OP_PEND;
                    else if (key_code == KEY_ENTER && r_entry_active)
                        w_state_nxt = ST_PUSH_PEND;
                    else if (key_code == KEY_CLEAR && !r_entry_active)
                        w_state_nxt = ST_OP_PEND;
                end
            end
            ST_PUSH_PEND: if (w_hs) w_state_nxt = r_has_op ? ST_OP_PEND : ST_IDLE;
            ST_OP_PEND:   if (w_hs) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_acc_nxt       = r_acc;
        w_active_nxt    = r_entry_active;
        w_has_op_nxt    = r_has_op;
        w_lat_op_nxt    = r_lat_op;
        w_cmd_valid_nxt = r_cmd_valid;
        w_cmd_op_nxt    = r_cmd_op;
        w_cmd_data_nxt  = r_cmd_data;
        w_ovf_nxt       = 1'b0;
        w_drop_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    if (w_is_digit) begin
                        if (w_digit_ovf) begin
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_acc_nxt    = w_sum;
                            w_active_nxt = 1'b1;
                        end
                    end else if (w_is_oper || key_code == KEY_ENTER) begin
                        if (r_entry_active) begin
                            w_cmd_valid_nxt = 1'b1;
                            w_cmd_op_nxt    = PUSH;
                            w_cmd_data_nxt  = r_acc;
                            w_has_op_nxt    = w_is_oper;
                            w_lat_op_nxt    = key_to_op(key_code);
                        end else if (w_is_oper) begin
                            w_cmd_valid_nxt = 1'b1;
                            w_cmd_op_nxt    = key_to_op(key_code);
                            w_cmd_data_nxt  = '0;
                        end
                    end else begin
                        if (r_entry_active) begin
                            w_acc_nxt    = '0;
                            w_active_nxt = 1'b0;
                        end else begin
                            w_cmd_valid_nxt = 1'b1;
                            w_cmd_op_nxt    = CLR;
                            w_cmd_data_nxt  = '0;
                        end
                    end
                end
            end
            ST_PUSH_PEND: begin
                w_drop_nxt = w_event;
                if (w_hs) begin
                    w_acc_nxt    = '0;
                    w_active_nxt = 1'b0;
                    w_has_op_nxt = 1'b0;
                    // Latched operator follows the PUSH with no idle bubble.
                    if (r_has_op) begin
                        w_cmd_op_nxt   = r_lat_op;
                        w_cmd_data_nxt = '0;
                    end else begin
                        w_cmd_valid_nxt = 1'b0;
                    end
                end
            end
            ST_OP_PEND: begin
                w_drop_nxt = w_event;
                if (w_hs) w_cmd_valid_nxt = 1'b0;
            end
            default: w_cmd_valid_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc          <= '0;
            r_entry_active <= 1'b0;
            r_key_prev     <= 1'b1;
            r_has_op       <= 1'b0;
            r_lat_op       <= PUSH;
            r_cmd_valid    <= 1'b0;
            r_cmd_op       <= PUSH;
            r_cmd_data     <= '0;
            r_entry_ovf    <= 1'b0;
            r_key_drop     <= 1'b0;
        end else begin
            r_acc          <= w_acc_nxt;
            r_entry_active <= w_active_nxt;
            r_key_prev     <= key_valid;
            r_has_op       <= w_has_op_nxt;
            r_lat_op       <= w_lat_op_nxt;
            r_cmd_valid    <= w_cmd_valid_nxt;
            r_cmd_op       <= w_cmd_op_nxt;
            r_cmd_data     <= w_cmd_data_nxt;
            r_entry_ovf    <= w_ovf_nxt;
            r_key_drop     <= w_drop_nxt;
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_op    = r_cmd_op;
    assign cmd_data  = r_cmd_data;
    assign entry_ovf = r_entry_ovf;
    assign key_drop  = r_key_drop;

`ifdef PARSER_ECHO_EN
    assign entry_value  = r_acc;
    assign entry_active = r_entry_active;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_token_parser.sv
// ============================================================================
// tb_key_token_parser: directed self-checking bench for key_token_parser.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_token_parser;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       key_code = 4'h0;
    logic             key_valid = 1'b0;
    logic             cmd_valid;
    logic             cmd_ready = 1'b0;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             entry_ovf;
    logic             key_drop;
`ifdef PARSER_ECHO_EN
    logic [WIDTH-1:0] entry_value;
    logic [0:0]       entry_active;
`endif

    int total = 0;
    int bad   = 0;

    key_token_parser #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_valid (key_valid),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .entry_ovf (entry_ovf),
        .key_drop  (key_drop)
`ifdef PARSER_ECHO_EN
        ,
        .entry_value  (entry_value),
        .entry_active (entry_active)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [2:0] E_PUSH = 3'd0, E_ADD = 3'd1, E_SUB = 3'd2,
                           E_MUL = 3'd3, E_CLR = 3'd5;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_cmd(input string tag, input logic v, input logic [2:0] op,
                           input logic [WIDTH-1:0] d);
        chk({tag, ".valid"}, 32'(cmd_valid), 32'(v));
        if (v) begin
            chk({tag, ".op"},   32'(cmd_op),   32'(op));
            chk({tag, ".data"}, 32'(cmd_data), 32'(d));
        end
    endtask

    // One-cycle key press; caller samples the event results on return.
    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic digit(input logic [3:0] k);
        press(k);
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst.valid", 32'(cmd_valid), 0);
        chk("rst.op",    32'(cmd_op),    0);
        chk("rst.data",  32'(cmd_data),  0);
        chk("rst.ovf",   32'(entry_ovf), 0);
        chk("rst.drop",  32'(key_drop),  0);
        rst = 1'b0;
        tick();

        // 1,2,3 then ADD: PUSH 123 followed immediately by ADD
        cmd_ready = 1'b1;
        digit(4'd1); digit(4'd2); digit(4'd3);
        press(4'hA);
        chk_cmd("t1.push", 1'b1, E_PUSH, 16'd123);
        tick();
        chk_cmd("t1.add", 1'b1, E_ADD, 16'd0);
        tick();
        chk_cmd("t1.idle", 1'b0, E_PUSH, 16'd0);
        tick();

        // saturation at 65535, digit 9 rejected
        digit(4'd6); digit(4'd5); digit(4'd5); digit(4'd3);
        press(4'd5);
        chk("t2.ovf_no", 32'(entry_ovf), 0);
        tick();
        press(4'd9);
        chk("t2.ovf_pulse", 32'(entry_ovf), 1);
        tick();
        chk("t2.ovf_clear", 32'(entry_ovf), 0);
        press(4'hD);
        chk_cmd("t2.push", 1'b1, E_PUSH, 16'd65535);
        tick();
        chk_cmd("t2.idle", 1'b0, E_PUSH, 16'd0);
        tick();

        // stall: PUSH 42 held while ready low, key 7 dropped, then SUB
        cmd_ready = 1'b0;
        digit(4'd4); digit(4'd2);
        press(4'hB);
        chk_cmd("t3.push", 1'b1, E_PUSH, 16'd42);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_cmd("t3.hold", 1'b1, E_PUSH, 16'd42);
        end
        press(4'd7);
        chk("t3.drop", 32'(key_drop), 1);
        chk_cmd("t3.hold7", 1'b1, E_PUSH, 16'd42);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3.drop_end", 32'(key_drop), 0);
            chk_cmd("t3.hold2", 1'b1, E_PUSH, 16'd42);
        end
        cmd_ready = 1'b1;
        tick();
        chk_cmd("t3.sub", 1'b1, E_SUB, 16'd0);
        tick();
        chk_cmd("t3.idle", 1'b0, E_PUSH, 16'd0);
        tick();
        press(4'hD);
        chk_cmd("t3.no_entry", 1'b0, E_PUSH, 16'd0);
        tick();

        // long held level: one digit only, re-press gives 55
        key_code  = 4'd5;
        key_valid = 1'b1;
        repeat (5000) tick();
        key_valid = 1'b0;
        tick();
        digit(4'd5);
        press(4'hD);
        chk_cmd("t4.push55", 1'b1, E_PUSH, 16'd55);
        tick();
        chk_cmd("t4.idle", 1'b0, E_PUSH, 16'd0);
        tick();

        // E with no entry issues CLR
        press(4'hE);
        chk_cmd("t5.clr", 1'b1, E_CLR, 16'd0);
        tick();
        chk_cmd("t5.idle", 1'b0, E_PUSH, 16'd0);
        tick();

        // 9, E, D: entry cleared silently, D ignored
        digit(4'd9);
        press(4'hE);
        chk_cmd("t6.e", 1'b0, E_PUSH, 16'd0);
        tick();
        press(4'hD);
        chk_cmd("t6.d", 1'b0, E_PUSH, 16'd0);
        tick();
        press(4'hC);
        chk_cmd("t6.mul", 1'b1, E_MUL, 16'd0);
        tick();
        chk_cmd("t6.idle", 1'b0, E_PUSH, 16'd0);
        tick();

        // reset while PUSH pending; key held across release is not an event
        cmd_ready = 1'b0;
        digit(4'd8);
        press(4'hC);
        chk_cmd("t7.pend", 1'b1, E_PUSH, 16'd8);
        rst       = 1'b1;
        key_code  = 4'd3;
        key_valid = 1'b1;
        tick();
        chk("t7.rst_valid", 32'(cmd_valid), 0);
        chk("t7.rst_data",  32'(cmd_data),  0);
        rst = 1'b0;
        tick();
        tick();
        chk("t7.no_event_valid", 32'(cmd_valid), 0);
        chk("t7.no_event_ovf",   32'(entry_ovf), 0);
        chk("t7.no_event_drop",  32'(key_drop),  0);
        key_valid = 1'b0;
        tick();
        cmd_ready = 1'b1;
        press(4'hD);
        chk_cmd("t7.acc_lost", 1'b0, E_PUSH, 16'd0);
        tick();
        press(4'hA);
        chk_cmd("t7.add", 1'b1, E_ADD, 16'd0);
        tick();
        chk_cmd("t7.idle", 1'b0, E_PUSH, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_token_parser.md
Name: key_token_parser

Overview:
- Sits directly downstream of the keypad decoder and consumes its 4-bit key code and new-token flag.
- Assembles decimal digit keys into an unsigned operand.
- Turns operator and control keys into a sequenced command stream for the stack/ALU stage.
- Commands use a valid/ready handshake, so the stack may stall the parser.

Parameters:
- WIDTH, 16, operand width in bits; the accumulator saturates at 2^WIDTH-1 by rejecting digits.

Ports:
- clk  in  1  system clock (100 MHz), single clock domain.
- rst  in  1  synchronous, active-high reset.
- key_code  in  4  key value from the decoder (0-9 digits, A-F functions).
- key_valid  in  1  decoder new-token level; may stay high for many cycles per press.
- cmd_valid  out  1  command present on cmd_op/cmd_data.
- cmd_ready  in  1  downstream accepts the command on a cycle where cmd_valid=1.
- cmd_op  out  3  opcode (see package).
- cmd_data  out  WIDTH  operand; meaningful only for PUSH, 0 otherwise.
- entry_ovf  out  1  one-cycle pulse when a digit is rejected for overflow.
- key_drop  out  1  one-cycle pulse when a key event arrives while a command is pending.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high (rst).
  - Reset values: cmd_valid=0, cmd_op=0, cmd_data=0, entry_ovf=0, key_drop=0.
  - Internal reset values: acc=0, entry_active=0, state=IDLE, key_prev=1.
- Key event:
  - An event is key_valid=1 while key_prev=0, with key_prev registered every cycle.
  - key_prev resets to 1, so a level held high across reset release produces no event.
  - key_code is sampled in the event cycle.
- Key map:
  - 0-9 digit; A ADD; B SUB; C MUL; D ENTER; E CLEAR; F DROP.
- States: IDLE, PUSH_PEND, OP_PEND.
- IDLE, digit d:
  - If acc*10+d (computed WIDTH+4 bits) <= 2^WIDTH-1, then acc<=acc*10+d and entry_active<=1.
  - Otherwise acc is unchanged and entry_ovf pulses.
  - Takes effect at the edge ending the event cycle; no command is issued.
- IDLE, A/B/C/F:
  - If entry_active: next cycle cmd_valid=1, op=PUSH, data=acc; state PUSH_PEND; the operator is latched.
  - Otherwise: next cycle cmd_valid=1 with the operator opcode; state OP_PEND.
- IDLE, D:
  - If entry_active: PUSH acc, then return to IDLE with no operator.
  - Otherwise: ignored.
- IDLE, E:
  - If entry_active: acc<=0, entry_active<=0, no command.
  - Otherwise: issue CLR (state OP_PEND).
- PUSH_PEND:
  - Hold cmd_valid, cmd_op and cmd_data stable until cmd_valid&cmd_ready at an edge.
  - On that edge: acc<=0, entry_active<=0.
  - If an operator is latched: next cycle present it (OP_PEND), i.e. zero bubble between PUSH and operator.
  - Otherwise: cmd_valid<=0 and go to IDLE.
- OP_PEND:
  - Hold until handshake, then cmd_valid<=0 and go to IDLE.
- Back-to-back: a handshake edge never overlaps with a new command from IDLE; at least one IDLE cycle between independent commands.
- Key event in PUSH_PEND/OP_PEND:
  - Event is discarded and key_drop pulses.
  - State and acc are unaffected.
- cmd_ready high while cmd_valid=0: ignored.
- Reset mid-command: cmd_valid=0 the cycle after rst; the pending command is lost and acc is cleared.
- Latency: key event edge to cmd_valid=1 is 1 cycle.

Optional Feature:
- Macro: PARSER_ECHO_EN.
- Defined:
  - Adds outputs entry_value[WIDTH-1:0] (equal to acc) and entry_active[0:0] for the display driver.
  - Both are registered and reset to 0.
  - entry_value clears on the same edge acc clears.
- Undefined:
  - Ports are absent.
  - acc and entry_active remain internal; behaviour is otherwise identical.

Decomposition:
- Package calc_pkg:
  - Opcode enum, 3 bits: PUSH=0, ADD=1, SUB=2, MUL=3, DROP=4, CLR=5.
  - Key-code constants: KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_MUL=4'hC, KEY_ENTER=4'hD, KEY_CLEAR=4'hE, KEY_DROP=4'hF.
  - Parser state enum.
- Sub-module decimal_accumulator:
  - Purely combinational times-10-plus-digit with overflow flag, parameterised by WIDTH.
  - The FSM stays in key_token_parser.

Test Plan:
- Keys 1,2,3 then A, cmd_ready=1:
  - PUSH data=123, next cycle ADD data=0.
  - Then cmd_valid=0 and acc=0.
- WIDTH=16, keys 6,5,5,3,5 then 9:
  - acc=65535 after 5; digit 9 rejected with entry_ovf pulse.
  - D then gives PUSH 65535.
- Keys 4,2 then B, cmd_ready=0 for 10 cycles:
  - PUSH 42 held stable for 10 cycles.
  - Key 7 pressed meanwhile produces key_drop with no acc change.
  - After ready: SUB issued.
- key_valid held high for 5000 cycles with code 5:
  - Exactly one digit accepted.
  - Release then re-press adds a second digit, giving acc=55.
- E with no entry issues CLR.
- Keys 9, E, D: no command, acc=0.
- rst asserted while cmd_valid=1 (PUSH_PEND):
  - cmd_valid=0 next cycle; state IDLE.
  - key_valid high at release produces no event.
